// File: rtl/mips_exec_stage_if.sv
// Operand/result bundle for the MIPS-lite execute stage.
// Inputs:  en (capture enable), aluop1/aluop0 (main-control ALU op), funct[3:0],
//          a/b (ALU operands), pc (program counter), imm16 (instruction bits [15:0]).
// Outputs: result, zero, gout, balrz, pc_plus4, branch_target (all registered).
interface mips_exec_stage_if;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned GOUT_W  = 3;

  logic                 en;
  logic                 aluop1;
  logic                 aluop0;
  logic [FUNCT_W-1:0]   funct;
  logic [DATA_W-1:0]    a;
  logic [DATA_W-1:0]    b;
  logic [DATA_W-1:0]    pc;
  logic [IMM_W-1:0]     imm16;

  logic [DATA_W-1:0]    result;
  logic                 zero;
  logic [GOUT_W-1:0]    gout;
  logic                 balrz;
  logic [DATA_W-1:0]    pc_plus4;
  logic [DATA_W-1:0]    branch_target;

  // Side that supplies operands and consumes results
  modport master (
    output en, aluop1, aluop0, funct, a, b, pc, imm16,
    input  result, zero, gout, balrz, pc_plus4, branch_target
  );

  // Execute stage itself
  modport slave (
    input  en, aluop1, aluop0, funct, a, b, pc, imm16,
    output result, zero, gout, balrz, pc_plus4, branch_target
  );
endinterface

// File: rtl/mips_exec_stage.sv
// Execute-stage datapath slice: ALU-control decode, 32-bit ALU with zero flag,
// PC+4 incrementer and branch-target adder, all captured in one output register.
// Ports: clk, reset (synchronous, active-high), bus (mips_exec_stage_if.slave).
module mips_exec_stage (
  input  logic               clk,
  input  logic               reset,
  mips_exec_stage_if.slave   bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned GOUT_W = 3;

  localparam logic [GOUT_W-1:0] G_AND = 3'b000;
  localparam logic [GOUT_W-1:0] G_OR  = 3'b001;
  localparam logic [GOUT_W-1:0] G_ADD = 3'b010;
  localparam logic [GOUT_W-1:0] G_SUB = 3'b110;
  localparam logic [GOUT_W-1:0] G_SLT = 3'b111;

  logic [GOUT_W-1:0] gout_c;
  logic              balrz_c;
  logic [DATA_W-1:0] alu_c;
  logic [DATA_W-1:0] pc_plus4_c;
  logic [DATA_W-1:0] branch_target_c;

  // ALU-control decode; aluop1 alone selects R-type decode
  always_comb begin
    gout_c  = G_ADD;
    balrz_c = 1'b0;
    if (bus.aluop1) begin
      case (bus.funct)
        4'b0000: gout_c = G_ADD;
        4'b0010: gout_c = G_SUB;
        4'b0100: gout_c = G_AND;
        4'b0101: gout_c = G_OR;
        4'b1010: gout_c = G_SLT;
        4'b0110: begin
          gout_c  = G_SUB;
          balrz_c = 1'b1;
        end
        default: gout_c = G_ADD;
      endcase
    end else if (bus.aluop0) begin
      gout_c = G_SUB;
    end
  end

  // ALU; unused codes yield zero
  always_comb begin
    alu_c = '0;
    case (gout_c)
      G_AND:   alu_c = bus.a & bus.b;
      G_OR:    alu_c = bus.a | bus.b;
      G_ADD:   alu_c = bus.a + bus.b;
      G_SUB:   alu_c = bus.a - bus.b;
      G_SLT:   alu_c = DATA_W'($signed(bus.a) < $signed(bus.b));
      default: alu_c = '0;
    endcase
  end

  // PC incrementer and branch-target adder (word offset, sign-extended)
  always_comb begin
    pc_plus4_c      = bus.pc + DATA_W'(4);
    branch_target_c = pc_plus4_c + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  end

  // Output register stage; reset overrides enable
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result        <= '0;
      bus.zero          <= 1'b0;
      bus.gout          <= '0;
      bus.balrz         <= 1'b0;
      bus.pc_plus4      <= '0;
      bus.branch_target <= '0;
    end else if (bus.en) begin
      bus.result        <= alu_c;
      bus.zero          <= (alu_c == '0);
      bus.gout          <= gout_c;
      bus.balrz         <= balrz_c;
      bus.pc_plus4      <= pc_plus4_c;
      bus.branch_target <= branch_target_c;
    end
  end
endmodule

// File: tb/tb_mips_exec_stage.sv
// Directed-vector bench for mips_exec_stage with hand-computed expectations.
module tb_mips_exec_stage;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mips_exec_stage_if bus ();

  mips_exec_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one operand set, clock it, and sample just after the edge
  task automatic step(input logic rst, input logic en, input logic [1:0] aluop,
                      input logic [3:0] funct, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [15:0] imm);
    reset      = rst;
    bus.en     = en;
    bus.aluop1 = aluop[1];
    bus.aluop0 = aluop[0];
    bus.funct  = funct;
    bus.a      = a;
    bus.b      = b;
    bus.pc     = pc;
    bus.imm16  = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] res, input logic z,
                         input logic [2:0] g, input logic bz,
                         input logic [31:0] p4, input logic [31:0] bt);
    chk({tag, ".result"}, bus.result, res);
    chk({tag, ".zero"}, 32'(bus.zero), 32'(z));
    chk({tag, ".gout"}, 32'(bus.gout), 32'(g));
    chk({tag, ".balrz"}, 32'(bus.balrz), 32'(bz));
    chk({tag, ".pc_plus4"}, bus.pc_plus4, p4);
    chk({tag, ".branch_target"}, bus.branch_target, bt);
  endtask

  initial begin
    // Reset with arbitrary inputs, then hold with en=0
    step(1'b1, 1'b1, 2'b10, 4'b0110, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1000, 16'h1234);
    chk_all("reset", 32'h0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 2'b10, 4'b0110, 32'h5, 32'h5, 32'h2000, 16'h0001);
    chk_all("post_reset_hold", 32'h0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0);

    // Load/store add; funct ignored when aluop=00
    step(1'b0, 1'b1, 2'b00, 4'b0110, 32'h10, 32'h4, 32'h100, 16'h0001);
    chk_all("lw_add", 32'h14, 1'b0, 3'b010, 1'b0, 32'h104, 32'h108);
    step(1'b0, 1'b1, 2'b00, 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 16'h0000);
    chk("add_wrap.result", bus.result, 32'h0);
    chk("add_wrap.zero", 32'(bus.zero), 32'h1);

    // Branch compare with backward branch target
    step(1'b0, 1'b1, 2'b01, 4'b0101, 32'h1234, 32'h1234, 32'h8, 16'hFFFE);
    chk_all("beq", 32'h0, 1'b1, 3'b110, 1'b0, 32'hC, 32'h4);

    // R-type sweep
    step(1'b0, 1'b1, 2'b10, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 16'h0);
    chk("and.result", bus.result, 32'h00F000F0);
    chk("and.gout", 32'(bus.gout), 32'h0);
    step(1'b0, 1'b1, 2'b10, 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 16'h0);
    chk("or.result", bus.result, 32'hFFF0FFF0);
    chk("or.gout", 32'(bus.gout), 32'h1);
    step(1'b0, 1'b1, 2'b10, 4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 16'h0);
    chk("sub.result", bus.result, 32'hE100E100);
    chk("sub.gout", 32'(bus.gout), 32'h6);

    // Signed SLT both ways, add overflow wrap
    step(1'b0, 1'b1, 2'b10, 4'b1010, 32'h80000000, 32'h1, 32'h0, 16'h0);
    chk("slt_neg.result", bus.result, 32'h1);
    chk("slt_neg.gout", 32'(bus.gout), 32'h7);
    chk("slt_neg.zero", 32'(bus.zero), 32'h0);
    step(1'b0, 1'b1, 2'b11, 4'b1010, 32'h1, 32'h80000000, 32'h0, 16'h0);
    chk("slt_swap.result", bus.result, 32'h0);
    chk("slt_swap.zero", 32'(bus.zero), 32'h1);
    step(1'b0, 1'b1, 2'b10, 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h0, 16'h0);
    chk("add_ovf.result", bus.result, 32'h80000000);
    chk("add_ovf.gout", 32'(bus.gout), 32'h2);

    // Unlisted funct falls back to add
    step(1'b0, 1'b1, 2'b10, 4'b1111, 32'h3, 32'h4, 32'h0, 16'h0);
    chk("funct_default.result", bus.result, 32'h7);
    chk("funct_default.gout", 32'(bus.gout), 32'h2);

    // balrz decode, then hold with en=0
    step(1'b0, 1'b1, 2'b10, 4'b0110, 32'h5, 32'h5, 32'h40, 16'h0010);
    chk_all("balrz", 32'h0, 1'b1, 3'b110, 1'b1, 32'h44, 32'h84);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 32'h1, 32'h2, 32'h500, 16'h0003);
    chk_all("hold", 32'h0, 1'b1, 3'b110, 1'b1, 32'h44, 32'h84);
    step(1'b0, 1'b1, 2'b00, 4'b0110, 32'h1, 32'h2, 32'hFFFFFFFC, 16'h7FFF);
    chk_all("aluop00_f0110", 32'h3, 1'b0, 3'b010, 1'b0, 32'h0, 32'h0001FFFC);

    // Reset wins over enable mid-stream
    step(1'b1, 1'b1, 2'b10, 4'b0101, 32'hFFFF0000, 32'h1, 32'h20, 16'h0004);
    chk_all("reset_prio", 32'h0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
